// File: rtl/udma_hyper_responder.sv
`default_nettype none
// ============================================================================
// Module   : udma_hyper_responder
// Brief    : HyperRAM-style responder on the controller's 16-bit per-cycle
//            pad view: CA decode, fixed latency, linear/wrapped bursts.
// Revision : 1.0  initial release
// ============================================================================
module udma_hyper_responder #(
    parameter int          ADDR_W  = 10,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0_VAL = 16'h0C81,
    parameter logic [15:0] CR0_RST = 16'h8F1F
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        hyper_cs_ni,
    input  logic [15:0] hyper_dq_i,
    input  logic [1:0]  hyper_rwds_i,
    output logic [15:0] hyper_dq_o,
    output logic        hyper_dq_oe_o,
    output logic [1:0]  hyper_rwds_o,
    output logic        hyper_rwds_oe_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_CA   = 3'd1;
    localparam logic [2:0]  S_LAT  = 3'd2;
    localparam logic [2:0]  S_RD   = 3'd3;
    localparam logic [2:0]  S_WR   = 3'd4;
    localparam logic [15:0] c_LAT_LAST = 16'(LATENCY - 1);

    logic [2:0]        r_state;
    logic [15:0]       r_cnt;
    logic [31:0]       r_ca_hi;
    logic              r_rw;
    logic              r_reg;
    logic              r_lin;
    logic              r_first;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cr0;
    logic [15:0]       r_dq;
    logic              r_dq_oe;
    logic [1:0]        r_rwds;
    logic              r_rwds_oe;
    logic              r_err;
    logic [15:0]       r_mem [2**ADDR_W];

    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_gmask;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_next;
    logic [15:0]       w_rd_data;
    logic              w_mem_we;

    // Start address is {CA[44:16], CA[2:0]}; the last CA word is still on the bus.
    assign w_a0 = ADDR_W'({r_ca_hi[28:0], hyper_dq_i[2:0]});

    always_comb begin
        w_gmask = ADDR_W'(63);
        case (r_cr0[1:0])
            2'b00:   w_gmask = ADDR_W'(63);
            2'b01:   w_gmask = ADDR_W'(31);
            2'b10:   w_gmask = ADDR_W'(7);
            default: w_gmask = ADDR_W'(15);
        endcase
    end

    assign w_inc     = r_addr + ADDR_W'(1);
    assign w_next    = r_lin ? w_inc : ((r_addr & ~w_gmask) | (w_inc & w_gmask));
    assign w_rd_data = r_reg ? (r_addr[0] ? r_cr0 : ID0_VAL) : r_mem[r_addr];
    assign w_mem_we  = !rst_i && !hyper_cs_ni && (r_state == S_WR) && !r_reg;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ca_hi   <= '0;
            r_rw      <= 1'b0;
            r_reg     <= 1'b0;
            r_lin     <= 1'b0;
            r_first   <= 1'b0;
            r_addr    <= '0;
            r_cr0     <= CR0_RST;
            r_dq      <= '0;
            r_dq_oe   <= 1'b0;
            r_rwds    <= '0;
            r_rwds_oe <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (hyper_cs_ni) begin
                r_state   <= S_IDLE;
                r_dq      <= '0;
                r_dq_oe   <= 1'b0;
                r_rwds    <= '0;
                r_rwds_oe <= 1'b0;
                r_err     <= (r_state == S_CA) || (r_state == S_LAT);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_ca_hi[31:16] <= hyper_dq_i;
                        r_cnt          <= 16'd1;
                        r_state        <= S_CA;
                        r_rwds_oe      <= 1'b1;
                        r_rwds         <= '0;
                    end
                    S_CA: begin
                        if (r_cnt == 16'd1) begin
                            r_ca_hi[15:0] <= hyper_dq_i;
                            r_cnt         <= 16'd2;
                        end else begin
                            r_rw    <= r_ca_hi[31];
                            r_reg   <= r_ca_hi[30];
                            r_lin   <= r_ca_hi[29];
                            r_addr  <= w_a0;
                            r_cnt   <= '0;
                            r_first <= 1'b1;
                            // Register writes skip the latency phase entirely.
                            if (!r_ca_hi[31] && r_ca_hi[30]) begin
                                r_state   <= S_WR;
                                r_rwds_oe <= 1'b0;
                            end else begin
                                r_state <= S_LAT;
                            end
                        end
                    end
                    S_LAT: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == c_LAT_LAST) begin
                            r_state <= r_rw ? S_RD : S_WR;
                            if (!r_rw) begin
                                r_rwds_oe <= 1'b0;
                            end
                        end
                    end
                    S_RD: begin
                        r_dq      <= w_rd_data;
                        r_dq_oe   <= 1'b1;
                        r_rwds    <= 2'b10;
                        r_rwds_oe <= 1'b1;
                        if (!r_reg) begin
                            r_addr <= w_next;
                        end
                    end
                    S_WR: begin
                        r_first <= 1'b0;
                        if (r_reg && r_first) begin
                            r_cr0 <= hyper_dq_i;
                        end
                        if (!r_reg) begin
                            r_addr <= w_next;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Array is deliberately not reset; masked bytes keep their old contents.
    always_ff @(posedge sys_clk_i) begin
        if (w_mem_we) begin
            if (!hyper_rwds_i[1]) begin
                r_mem[r_addr][15:8] <= hyper_dq_i[15:8];
            end
            if (!hyper_rwds_i[0]) begin
                r_mem[r_addr][7:0] <= hyper_dq_i[7:0];
            end
        end
    end

    assign hyper_dq_o      = r_dq;
    assign hyper_dq_oe_o   = r_dq_oe;
    assign hyper_rwds_o    = r_rwds;
    assign hyper_rwds_oe_o = r_rwds_oe;
    assign busy_o          = (r_state != S_IDLE);
    assign err_o           = r_err;

endmodule
`default_nettype wire
